// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// datapath mux select codes and the packed control-word bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMCALC  = 4'd2,
    S_MEMLOAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_REGWRITE = 4'd5,
    S_REXEC    = 4'd6,
    S_RFINISH  = 4'd7,
    S_OREXEC   = 4'd8,
    S_ORFINISH = 4'd9,
    S_BR       = 4'd10,
    S_JAL      = 4'd11
  } state_e;

  localparam logic [2:0] OP_ADDU = 3'd0;
  localparam logic [2:0] OP_SUBU = 3'd1;
  localparam logic [2:0] OP_ORI  = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;
  localparam logic [2:0] OP_JAL  = 3'd6;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic       ALU_A_PC = 1'b0;
  localparam logic       ALU_A_RA = 1'b1;

  localparam logic [1:0] ALU_B_4      = 2'd0;
  localparam logic [1:0] ALU_B_RB     = 2'd1;
  localparam logic [1:0] ALU_B_IMM    = 2'd2;
  localparam logic [1:0] ALU_B_IMM_SH = 2'd3;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;

  localparam logic       EXT_ZERO = 1'b0;
  localparam logic       EXT_SIGN = 1'b1;

  localparam logic [1:0] RF_W_RT  = 2'd0;
  localparam logic [1:0] RF_W_RD  = 2'd1;
  localparam logic [1:0] RF_W_R31 = 2'd2;

  localparam logic [1:0] RF_DIN_ALU = 2'd0;
  localparam logic [1:0] RF_DIN_DR  = 2'd1;
  localparam logic [1:0] RF_DIN_PC  = 2'd2;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       ab_wr;
    logic       alu_out_wr;
    logic       target_wr;
    logic       dr_wr;
    logic       dm_wr;
    logic       rf_wr;
    logic [1:0] pc_src;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_ctrl;
    logic       ext_sz;
    logic [1:0] rf_w_sel;
    logic [1:0] rf_din_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mc_perf_cnt.sv
// Free-running cycle counter and instruction-retire counter; both wrap.
module mc_perf_cnt
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (retire) ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM for the 7-op MIPS core.
// Build option MC_PERF_CNT_EN adds cyc_cnt/ret_cnt performance counters.
module mc_ctrl
  import mc_pkg::*;
`ifdef MC_PERF_CNT_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             zf,
  input  logic             im_ready,
  input  logic             dm_ready,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             ab_wr,
  output logic             alu_out_wr,
  output logic             target_wr,
  output logic             dr_wr,
  output logic             dm_wr,
  output logic             rf_wr,
  output logic [1:0]       pc_src,
  output logic             alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       alu_ctrl,
  output logic             ext_sz,
  output logic [1:0]       rf_w_sel,
  output logic [1:0]       rf_din_sel,
  output logic [3:0]       state_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  state_e state_q, state_d;
  ctrl_t  c, co;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    c       = CTRL_IDLE;
    case (state_q)
      S_FETCH: begin
        c.ir_wr = im_ready;
        c.pc_wr = im_ready;
        state_d = im_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively form the branch target while rA/rB are latched.
        c.ab_wr     = 1'b1;
        c.target_wr = 1'b1;
        c.alu_b_sel = ALU_B_IMM_SH;
        c.ext_sz    = EXT_SIGN;
        case (op)
          OP_ADDU, OP_SUBU: state_d = S_REXEC;
          OP_ORI:           state_d = S_OREXEC;
          OP_LW, OP_SW:     state_d = S_MEMCALC;
          OP_BEQ:           state_d = S_BR;
          OP_JAL:           state_d = S_JAL;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEMCALC: begin
        c.alu_a_sel  = ALU_A_RA;
        c.alu_b_sel  = ALU_B_IMM;
        c.ext_sz     = EXT_SIGN;
        c.alu_out_wr = 1'b1;
        state_d      = (op == OP_LW) ? S_MEMLOAD : S_MEMWRITE;
      end
      S_MEMLOAD: begin
        c.dr_wr = dm_ready;
        state_d = dm_ready ? S_REGWRITE : S_MEMLOAD;
      end
      S_MEMWRITE: begin
        // Held until the memory accepts; address/data come from registers.
        c.dm_wr = 1'b1;
        state_d = dm_ready ? S_FETCH : S_MEMWRITE;
      end
      S_REGWRITE: begin
        c.rf_wr      = 1'b1;
        c.rf_w_sel   = RF_W_RT;
        c.rf_din_sel = RF_DIN_DR;
        state_d      = S_FETCH;
      end
      S_REXEC: begin
        c.alu_a_sel  = ALU_A_RA;
        c.alu_b_sel  = ALU_B_RB;
        c.alu_ctrl   = op[0] ? ALU_SUB : ALU_ADD;
        c.alu_out_wr = 1'b1;
        state_d      = S_RFINISH;
      end
      S_RFINISH: begin
        c.rf_wr      = 1'b1;
        c.rf_w_sel   = RF_W_RD;
        c.rf_din_sel = RF_DIN_ALU;
        state_d      = S_FETCH;
      end
      S_OREXEC: begin
        c.alu_a_sel  = ALU_A_RA;
        c.alu_b_sel  = ALU_B_IMM;
        c.ext_sz     = EXT_ZERO;
        c.alu_ctrl   = ALU_OR;
        c.alu_out_wr = 1'b1;
        state_d      = S_ORFINISH;
      end
      S_ORFINISH: begin
        c.rf_wr      = 1'b1;
        c.rf_w_sel   = RF_W_RT;
        c.rf_din_sel = RF_DIN_ALU;
        state_d      = S_FETCH;
      end
      S_BR: begin
        c.alu_a_sel = ALU_A_RA;
        c.alu_b_sel = ALU_B_RB;
        c.alu_ctrl  = ALU_SUB;
        c.pc_src    = PC_SRC_BR;
        c.pc_wr     = zf;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        c.pc_src     = PC_SRC_JMP;
        c.pc_wr      = 1'b1;
        c.rf_wr      = 1'b1;
        c.rf_w_sel   = RF_W_R31;
        c.rf_din_sel = RF_DIN_PC;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates every output so pending writes drop in the same cycle.
  assign co         = rst ? c : CTRL_IDLE;
  assign pc_wr      = co.pc_wr;
  assign ir_wr      = co.ir_wr;
  assign ab_wr      = co.ab_wr;
  assign alu_out_wr = co.alu_out_wr;
  assign target_wr  = co.target_wr;
  assign dr_wr      = co.dr_wr;
  assign dm_wr      = co.dm_wr;
  assign rf_wr      = co.rf_wr;
  assign pc_src     = co.pc_src;
  assign alu_a_sel  = co.alu_a_sel;
  assign alu_b_sel  = co.alu_b_sel;
  assign alu_ctrl   = co.alu_ctrl;
  assign ext_sz     = co.ext_sz;
  assign rf_w_sel   = co.rf_w_sel;
  assign rf_din_sel = co.rf_din_sel;
  assign state_o    = state_q;

`ifdef MC_PERF_CNT_EN
  logic retire;
  assign retire = (state_q != S_FETCH) && (state_d == S_FETCH);

  mc_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk     (clk),
    .rst     (rst),
    .retire  (retire),
    .cyc_cnt (cyc_cnt),
    .ret_cnt (ret_cnt)
  );
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed vector bench for mc_ctrl; counter checks compile in with MC_PERF_CNT_EN.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] op = 3'd0;
  logic       zf = 1'b0, im_ready = 1'b0, dm_ready = 1'b0;
  logic       pc_wr, ir_wr, ab_wr, alu_out_wr, target_wr, dr_wr, dm_wr, rf_wr;
  logic [1:0] pc_src, alu_b_sel, alu_ctrl, rf_w_sel, rf_din_sel;
  logic       alu_a_sel, ext_sz;
  logic [3:0] state_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .zf(zf), .im_ready(im_ready), .dm_ready(dm_ready),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .ab_wr(ab_wr), .alu_out_wr(alu_out_wr),
    .target_wr(target_wr), .dr_wr(dr_wr), .dm_wr(dm_wr), .rf_wr(rf_wr),
    .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl),
    .ext_sz(ext_sz), .rf_w_sel(rf_w_sel), .rf_din_sel(rf_din_sel), .state_o(state_o)
`ifdef MC_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  // Enables: {pc_wr,ir_wr,ab_wr,alu_out_wr,target_wr,dr_wr,dm_wr,rf_wr}
  // Selects: {pc_src,alu_a_sel,alu_b_sel,alu_ctrl,ext_sz,rf_w_sel,rf_din_sel}
  logic [7:0]  en_act;
  logic [11:0] sel_act;
  assign en_act  = {pc_wr, ir_wr, ab_wr, alu_out_wr, target_wr, dr_wr, dm_wr, rf_wr};
  assign sel_act = {pc_src, alu_a_sel, alu_b_sel, alu_ctrl, ext_sz, rf_w_sel, rf_din_sel};

  localparam logic [7:0] EN0    = 8'b0000_0000;
  localparam logic [7:0] EN_F   = 8'b1100_0000;
  localparam logic [7:0] EN_D   = 8'b0010_1000;
  localparam logic [7:0] EN_AO  = 8'b0001_0000;
  localparam logic [7:0] EN_RF  = 8'b0000_0001;
  localparam logic [7:0] EN_PC  = 8'b1000_0000;
  localparam logic [7:0] EN_JAL = 8'b1000_0001;
  localparam logic [7:0] EN_DM  = 8'b0000_0010;
  localparam logic [7:0] EN_DR  = 8'b0000_0100;

  localparam logic [11:0] SEL0    = 12'b00_0_00_00_0_00_00;
  localparam logic [11:0] SEL_DEC = 12'b00_0_11_00_1_00_00;
  localparam logic [11:0] SEL_ADD = 12'b00_1_01_00_0_00_00;
  localparam logic [11:0] SEL_SUB = 12'b00_1_01_01_0_00_00;
  localparam logic [11:0] SEL_RD  = 12'b00_0_00_00_0_01_00;
  localparam logic [11:0] SEL_OR  = 12'b00_1_10_10_0_00_00;
  localparam logic [11:0] SEL_BR  = 12'b01_1_01_01_0_00_00;
  localparam logic [11:0] SEL_JAL = 12'b10_0_00_00_0_10_10;
  localparam logic [11:0] SEL_MC  = 12'b00_1_10_00_1_00_00;
  localparam logic [11:0] SEL_RW  = 12'b00_0_00_00_0_00_01;

  typedef struct packed {
    logic [2:0]  op;
    logic        zf;
    logic        im;
    logic        dm;
    logic [3:0]  st;
    logic [7:0]  en;
    logic [11:0] sel;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(input logic [2:0] o, input logic z, input logic im, input logic dm,
                             input logic [3:0] st, input logic [7:0] en, input logic [11:0] sel);
    V = {o, z, im, dm, st, en, sel};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check settled outputs.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    op = v.op; zf = v.zf; im_ready = v.im; dm_ready = v.dm;
    #1;
    chk({tag, ".state"}, 32'(state_o), 32'(v.st));
    chk({tag, ".en"},    32'(en_act),  32'(v.en));
    chk({tag, ".sel"},   32'(sel_act), 32'(v.sel));
  endtask

  initial begin
    // addu
    tbl.push_back(V(3'd0, 0, 0, 1, 4'd0,  EN0,   SEL0));
    tbl.push_back(V(3'd0, 0, 1, 1, 4'd0,  EN_F,  SEL0));
    tbl.push_back(V(3'd0, 0, 1, 1, 4'd1,  EN_D,  SEL_DEC));
    tbl.push_back(V(3'd0, 0, 1, 1, 4'd6,  EN_AO, SEL_ADD));
    tbl.push_back(V(3'd0, 0, 1, 1, 4'd7,  EN_RF, SEL_RD));
    // subu
    tbl.push_back(V(3'd1, 0, 1, 1, 4'd0,  EN_F,  SEL0));
    tbl.push_back(V(3'd1, 0, 1, 1, 4'd1,  EN_D,  SEL_DEC));
    tbl.push_back(V(3'd1, 0, 1, 1, 4'd6,  EN_AO, SEL_SUB));
    tbl.push_back(V(3'd1, 0, 1, 1, 4'd7,  EN_RF, SEL_RD));
    // ori
    tbl.push_back(V(3'd2, 0, 1, 1, 4'd0,  EN_F,  SEL0));
    tbl.push_back(V(3'd2, 0, 1, 1, 4'd1,  EN_D,  SEL_DEC));
    tbl.push_back(V(3'd2, 0, 1, 1, 4'd8,  EN_AO, SEL_OR));
    tbl.push_back(V(3'd2, 0, 1, 1, 4'd9,  EN_RF, SEL0));
    // beq taken, then not taken
    tbl.push_back(V(3'd5, 1, 1, 1, 4'd0,  EN_F,  SEL0));
    tbl.push_back(V(3'd5, 1, 1, 1, 4'd1,  EN_D,  SEL_DEC));
    tbl.push_back(V(3'd5, 1, 1, 1, 4'd10, EN_PC, SEL_BR));
    tbl.push_back(V(3'd5, 0, 1, 1, 4'd0,  EN_F,  SEL0));
    tbl.push_back(V(3'd5, 0, 1, 1, 4'd1,  EN_D,  SEL_DEC));
    tbl.push_back(V(3'd5, 0, 1, 1, 4'd10, EN0,   SEL_BR));
    // jal
    tbl.push_back(V(3'd6, 0, 1, 1, 4'd0,  EN_F,  SEL0));
    tbl.push_back(V(3'd6, 0, 1, 1, 4'd1,  EN_D,  SEL_DEC));
    tbl.push_back(V(3'd6, 0, 1, 1, 4'd11, EN_JAL, SEL_JAL));
    // illegal op: decode then straight back
    tbl.push_back(V(3'd7, 0, 1, 1, 4'd0,  EN_F,  SEL0));
    tbl.push_back(V(3'd7, 0, 1, 1, 4'd1,  EN_D,  SEL_DEC));
    // sw, memory ready at once
    tbl.push_back(V(3'd4, 0, 1, 1, 4'd0,  EN_F,  SEL0));
    tbl.push_back(V(3'd4, 0, 1, 1, 4'd1,  EN_D,  SEL_DEC));
    tbl.push_back(V(3'd4, 0, 1, 1, 4'd2,  EN_AO, SEL_MC));
    tbl.push_back(V(3'd4, 0, 1, 1, 4'd4,  EN_DM, SEL0));
    // im_ready low holds FETCH
    tbl.push_back(V(3'd4, 0, 0, 1, 4'd0,  EN0,   SEL0));
    tbl.push_back(V(3'd4, 0, 0, 1, 4'd0,  EN0,   SEL0));

    // Reset state, with im_ready high to prove enables are gated.
    #1 rst = 1'b0;
    im_ready = 1'b1;
    #2;
    chk("rst.state", 32'(state_o), 32'd0);
    chk("rst.en",    32'(en_act),  32'd0);
    chk("rst.sel",   32'(sel_act), 32'd0);
    @(negedge clk);
    im_ready = 1'b0;
    rst = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // lw with data memory stalled 3 cycles: 8 cycles FETCH to FETCH
    apply(V(3'd3, 0, 1, 0, 4'd0, EN_F,  SEL0),    "lw.f");
    apply(V(3'd3, 0, 1, 0, 4'd1, EN_D,  SEL_DEC), "lw.d");
    apply(V(3'd3, 0, 1, 0, 4'd2, EN_AO, SEL_MC),  "lw.mc");
    for (int k = 0; k < 3; k++)
      apply(V(3'd3, 0, 1, 0, 4'd3, EN0, SEL0), $sformatf("lw.stall%0d", k));
    apply(V(3'd3, 0, 1, 1, 4'd3, EN_DR, SEL0),    "lw.ml");
    apply(V(3'd3, 0, 1, 1, 4'd5, EN_RF, SEL_RW),  "lw.rw");
    apply(V(3'd3, 0, 0, 1, 4'd0, EN0,   SEL0),    "lw.back");

    // Reset asserted mid-MEMWRITE with dm_wr pending
    apply(V(3'd4, 0, 1, 0, 4'd0, EN_F,  SEL0),    "rsw.f");
    apply(V(3'd4, 0, 1, 0, 4'd1, EN_D,  SEL_DEC), "rsw.d");
    apply(V(3'd4, 0, 1, 0, 4'd2, EN_AO, SEL_MC),  "rsw.mc");
    apply(V(3'd4, 0, 1, 0, 4'd4, EN_DM, SEL0),    "rsw.mw0");
    apply(V(3'd4, 0, 1, 0, 4'd4, EN_DM, SEL0),    "rsw.mw1");
    #2 rst = 1'b0;
    #1;
    chk("rsw.dm_wr", 32'(dm_wr),   32'd0);
    chk("rsw.state", 32'(state_o), 32'd0);
    chk("rsw.en",    32'(en_act),  32'd0);
    @(negedge clk);
    #1;
    chk("rsw.hold", 32'(en_act), 32'd0);
    im_ready = 1'b0;
    rst = 1'b1;
    apply(V(3'd0, 0, 0, 0, 4'd0, EN0,  SEL0), "rsw.idle0");
    apply(V(3'd0, 0, 0, 0, 4'd0, EN0,  SEL0), "rsw.idle1");
    apply(V(3'd0, 0, 1, 1, 4'd0, EN_F, SEL0), "rsw.go");

`ifdef MC_PERF_CNT_EN
    // Ten back-to-back addu from a fresh reset
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("perf.rst_cyc", cyc_cnt, 32'd0);
    chk("perf.rst_ret", ret_cnt, 32'd0);
    @(negedge clk);
    op = 3'd0; im_ready = 1'b1; dm_ready = 1'b1;
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("perf.cyc", cyc_cnt, 32'd40);
    chk("perf.ret", ret_cnt, 32'd10);
    chk("perf.state", 32'(state_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
